// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced by a qualified pixel strobe,
// with a horizontal phase FSM and registered sync, blanking, position and pulse outputs.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_end,
  output logic       frame_start
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END     = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    H_ACT   = 2'd0,
    H_FRONT = 2'd1,
    H_SYNCP = 2'd2,
    H_BACK  = 2'd3
  } h_state_t;

  h_state_t   h_state;
  h_state_t   h_state_nxt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       adv;
  logic       h_wrap;
  logic       v_wrap;
  logic       von_nxt;
  logic       vs_nxt;

  // Strobe semantics: an advance happens on every clk where enable and pixel_tick are
  // both high; there is no backpressure, and with enable low everything holds.
  always_comb begin
    adv    = enable & pixel_tick;
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    h_state_nxt = h_state;
    case (h_state)
      H_ACT:   if (h_nxt == H_FRONT_START) h_state_nxt = H_FRONT;
      H_FRONT: if (h_nxt == H_SYNC_START)  h_state_nxt = H_SYNCP;
      H_SYNCP: if (h_nxt == H_BACK_START)  h_state_nxt = H_BACK;
      H_BACK:  if (h_wrap)                 h_state_nxt = H_ACT;
      default: h_state_nxt = H_BACK;
    endcase
  end

  // Outputs are computed from the post-advance values so they land on the same edge
  // as the counters they describe.
  always_comb begin
    von_nxt = (h_state_nxt == H_ACT) && (v_nxt < V_ACT_END);
    vs_nxt  = !((v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      h_state     <= H_BACK;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else if (adv) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      h_state     <= h_state_nxt;
      hsync       <= (h_state_nxt != H_SYNCP);
      vsync       <= vs_nxt;
      video_on    <= von_nxt;
      pix_x       <= von_nxt ? h_nxt : 10'd0;
      pix_y       <= von_nxt ? v_nxt : 10'd0;
      line_end    <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-horizontal / short-vertical instance checked cycle by
// cycle against a queued reference, plus a tiny 5x5 instance checked tick by tick.
module tb_video_timing_gen;

  // Main instance: default horizontal timing, vertical shrunk to 4/2/2/2 so a frame fits.
  localparam int H_T = 800;
  localparam int V_T = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, enable, pixel_tick;
  logic       hsync, vsync, video_on, line_end, frame_start;
  logic [9:0] pix_x, pix_y;

  logic       s_rst, s_en, s_tick;
  logic       s_hsync, s_vsync, s_video_on, s_line_end, s_frame_start;
  logic [9:0] s_pix_x, s_pix_y;

  video_timing_gen #(
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .pixel_tick(pixel_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .line_end(line_end), .frame_start(frame_start)
  );

  video_timing_gen #(
    .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clk(clk), .n_rst(s_rst), .enable(s_en), .pixel_tick(s_tick),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .line_end(s_line_end), .frame_start(s_frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Entry: [26]=clear stats, [25]=advance, [24:0]={hs,vs,von,x,y,le,fs}
  logic [26:0] exp_q[$];
  logic        clr_next = 1'b0;

  int         m_h, m_v;
  logic       m_hs, m_vs, m_von;
  logic [9:0] m_x, m_y;

  int st_adv, st_video, st_hs_low, st_hs_first, st_hs_last;
  int st_vs_low, st_vs_first, st_le, st_le_last, st_fs, st_max_x, st_max_y;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one clk of inputs and queue the outputs expected after the coming posedge.
  task automatic step(input logic r, input logic e, input logic p);
    logic le, fs, adv;
    @(negedge clk);
    n_rst = r; enable = e; pixel_tick = p;
    le = 1'b0; fs = 1'b0; adv = 1'b0;
    if (!r) begin
      m_h = H_T - 1; m_v = V_T - 1;
      m_hs = 1'b1; m_vs = 1'b1; m_von = 1'b0; m_x = '0; m_y = '0;
    end else if (e && p) begin
      adv = 1'b1;
      le  = (m_h == H_T - 1);
      fs  = le && (m_v == V_T - 1);
      if (le) begin
        m_h = 0;
        m_v = (m_v == V_T - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_von = (m_h < 640) && (m_v < 4);
      m_hs  = !((m_h >= 656) && (m_h < 752));
      m_vs  = !((m_v >= 6) && (m_v < 8));
      m_x   = m_von ? 10'(m_h) : 10'd0;
      m_y   = m_von ? 10'(m_v) : 10'd0;
    end
    exp_q.push_back({clr_next, adv, m_hs, m_vs, m_von, m_x, m_y, le, fs});
    clr_next = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: every queued entry is compared one step after the edge it describes.
  logic [26:0] mon_e;
  logic [24:0] mon_a;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start};
      if (mon_e[26]) begin
        st_adv = 0; st_video = 0; st_hs_low = 0; st_hs_first = -1; st_hs_last = -1;
        st_vs_low = 0; st_vs_first = -1; st_le = 0; st_le_last = -1; st_fs = 0;
        st_max_x = 0; st_max_y = 0;
      end
      n_tests++;
      if (mon_a !== mon_e[24:0]) begin
        n_fail++;
        $display("FAIL sb_out at adv %0d: got hs=%b vs=%b von=%b x=%0d y=%0d le=%b fs=%b expected hs=%b vs=%b von=%b x=%0d y=%0d le=%b fs=%b",
                 st_adv, hsync, vsync, video_on, pix_x, pix_y, line_end, frame_start,
                 mon_e[24], mon_e[23], mon_e[22], mon_e[21:12], mon_e[11:2], mon_e[1], mon_e[0]);
      end
      if (mon_e[25]) begin
        if (video_on) st_video++;
        if (!hsync) begin
          st_hs_low++;
          if (st_hs_first < 0) st_hs_first = st_adv;
          st_hs_last = st_adv;
        end
        if (!vsync) begin
          st_vs_low++;
          if (st_vs_first < 0) st_vs_first = st_adv;
        end
        if (line_end) begin
          st_le++;
          st_le_last = st_adv;
        end
        if (frame_start) st_fs++;
        if (int'(pix_x) > st_max_x) st_max_x = int'(pix_x);
        if (int'(pix_y) > st_max_y) st_max_y = int'(pix_y);
        st_adv++;
      end
    end
  end

  initial begin
    int n_align;
    int s_fs_cnt;
    n_rst = 1'b0; enable = 1'b0; pixel_tick = 1'b0;
    s_rst = 1'b0; s_en = 1'b1; s_tick = 1'b0;

    // Reset, first tick, then the rest of the first line at one tick per clk.
    clr_next = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    ticks(800);
    step(1'b1, 1'b1, 1'b0);
    check("line_adv", st_adv, 800);
    check("line_video_on", st_video, 640);
    check("line_hsync_low", st_hs_low, 96);
    check("line_hsync_first", st_hs_first, 656);
    check("line_hsync_last", st_hs_last, 751);
    check("line_le_count", st_le, 1);
    check("line_le_pos", st_le_last, 0);
    check("line_fs_count", st_fs, 1);
    ticks(1);
    step(1'b1, 1'b1, 1'b0);
    check("wrap_le_count", st_le, 2);
    check("wrap_le_pos", st_le_last, 800);
    check("wrap_fs_count", st_fs, 1);

    // Hold mid-line with pixel_tick toggling, then at the last pixel of a line.
    ticks(100);
    clr_next = 1'b1;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'(i % 2));
    ticks(1);
    step(1'b1, 1'b1, 1'b0);
    check("hold_adv", st_adv, 1);
    check("hold_resume_x", st_max_x, 101);
    check("hold_le", st_le, 0);
    ticks(698);
    repeat (10) step(1'b1, 1'b0, 1'b1);
    ticks(1);

    // Align to the frame boundary, then a whole frame at one tick every 4 clks.
    n_align = (V_T - 1 - m_v) * H_T + (H_T - 1 - m_h);
    ticks(n_align);
    clr_next = 1'b1;
    for (int i = 0; i < H_T * V_T; i++) begin
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    check("frame_adv", st_adv, 8000);
    check("frame_le_count", st_le, 10);
    check("frame_fs_count", st_fs, 1);
    check("frame_vsync_low", st_vs_low, 1600);
    check("frame_vsync_first", st_vs_first, 4800);
    check("frame_video_on", st_video, 2560);
    check("frame_hsync_low", st_hs_low, 960);
    check("frame_max_x", st_max_x, 639);
    check("frame_max_y", st_max_y, 3);

    // Reset mid-line inside both sync pulses, with enable and pixel_tick still high.
    ticks(7 * H_T + 700 + 1);
    step(1'b0, 1'b1, 1'b1);
    clr_next = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("rst_fs_count", st_fs, 1);
    check("rst_le_count", st_le, 1);
    check("rst_video_on", st_video, 1);
    step(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("sb_drain", exp_q.size(), 0);

    // Tiny 5x5 raster: frame every 25 ticks, hsync low only at h_cnt=3.
    s_fs_cnt = 0;
    @(negedge clk); s_rst = 1'b0; s_tick = 1'b1;
    @(negedge clk); s_rst = 1'b0; s_tick = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int h, v;
      h = i % 5;
      v = (i / 5) % 5;
      @(negedge clk); s_rst = 1'b1; s_tick = 1'b1;
      @(posedge clk); #1;
      check("s_hsync", s_hsync, (h != 3) ? 1 : 0);
      check("s_vsync", s_vsync, (v != 3) ? 1 : 0);
      check("s_video_on", s_video_on, (h < 2 && v < 2) ? 1 : 0);
      check("s_pix_x", s_pix_x, (h < 2 && v < 2) ? h : 0);
      check("s_line_end", s_line_end, (h == 0) ? 1 : 0);
      check("s_frame_start", s_frame_start, (i % 25 == 0) ? 1 : 0);
      if (s_frame_start) s_fs_cnt++;
    end
    check("s_fs_count", s_fs_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning); all SHALL be positive:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
REQ-002 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both SHALL be <= 1024.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on posedge
- n_rst  input  1  reset, synchronous, active-low
- enable  input  1  run/hold control
- pixel_tick  input  1  single-cycle pixel strobe from the clock divider
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high inside the visible region
- pix_x  output  10  visible column
- pix_y  output  10  visible row
- line_end  output  1  one-clk pulse on each line wrap
- frame_start  output  1  one-clk pulse on each frame start
REQ-004 Reset SHALL be synchronous and active-low: n_rst is sampled only on the posedge of clk, with no asynchronous path.

Function
REQ-005 An advance SHALL occur on every posedge where enable=1 and pixel_tick=1; pixel_tick high on consecutive cycles SHALL give one advance per cycle.
REQ-006 With enable=0, pixel_tick SHALL be ignored, counters and levels SHALL hold, and line_end and frame_start SHALL be 0.
REQ-007 On an advance, h_cnt SHALL count 0..H_TOTAL-1; when h_cnt=H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment, wrapping V_TOTAL-1 to 0.
REQ-008 The horizontal phase FSM SHALL have states H_ACT, H_FRONT, H_SYNCP and H_BACK, entered on the advance into h_cnt=0, H_ACTIVE, H_ACTIVE+H_FP and H_ACTIVE+H_FP+H_SYNC respectively; H_BACK SHALL go to H_ACT on the wrap.
REQ-009 All outputs SHALL be registered and SHALL change on the same edge as the counter advance they reflect (zero added latency relative to h_cnt/v_cnt).
REQ-010 hsync SHALL be 0 iff the FSM state is H_SYNCP (default h_cnt 656..751).
REQ-011 vsync SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default v_cnt 490..491).
REQ-012 video_on SHALL be 1 iff state=H_ACT and v_cnt < V_ACTIVE.
REQ-013 pix_x/pix_y SHALL equal h_cnt/v_cnt while video_on=1 and SHALL be 0 otherwise.
REQ-014 line_end SHALL be 1 for exactly the one clk following the advance that wraps h_cnt to 0.
REQ-015 frame_start SHALL be 1 for exactly the one clk following the advance that yields h_cnt=0 and v_cnt=0; it coincides with line_end.
REQ-016 Pulses SHALL NOT repeat or stretch when pixel_tick is held high; each wrap SHALL produce exactly one pulse.

Reset
REQ-017 With n_rst=0 at a posedge: h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, state=H_BACK, hsync=1, vsync=1, video_on=0, pix_x=0, pix_y=0, line_end=0, frame_start=0.
REQ-018 Reset SHALL override enable and pixel_tick, including mid-line and mid-pulse.
REQ-019 The first advance after reset SHALL produce (0,0) with frame_start=1, line_end=1 and video_on=1.

Verification
REQ-020 Reset, then one tick -> frame_start=1 and line_end=1 for 1 clk; pix_x=0, pix_y=0, video_on=1, hsync=1, vsync=1.
REQ-021 Ticks every clk for 1 line -> video_on high for 640 ticks; hsync low exactly on ticks 656..751 (96 ticks); line_end after tick 800 only.
REQ-022 A full frame at one tick every 4 clks -> 525 line_end pulses; 1 frame_start; vsync low for 2 lines (1600 ticks) starting at line 490; pix_y max 479, pix_x max 639.
REQ-023 enable=0 for 50 clks mid-line while pixel_tick toggles -> no counter change, no pulses; resumes at the next h_cnt.
REQ-024 n_rst asserted at h_cnt=700, v_cnt=491 (hsync=0, vsync=0) -> next clk: hsync=1, vsync=1, video_on=0; next tick -> frame_start.
REQ-025 Small parameters (2,1,1,1 / 2,1,1,1) -> H_TOTAL=5, V_TOTAL=5; frame_start every 25 ticks; hsync low only at h_cnt=3.
